plru_set_ctrl: RTL



---
 rtl/plru_pkg.sv | 57 +++++
 rtl/plru_victim_sel.sv | 59 +++++
 rtl/plru_set_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/plru_pkg.sv
// Shared types and tree-index helpers for the pseudo-LRU set controller.
// Node 0 is the root; node n has children 2n+1 (left, lower ways) and 2n+2.
package plru_pkg;

  localparam int MAX_WAY_N  = 8;
  localparam int MAX_NODE_N = MAX_WAY_N - 1;

  typedef logic [MAX_NODE_N-1:0] node_vec_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } sweep_state_e;

  function automatic int parent(input int n);
    return (n - 1) / 2;
  endfunction

  function automatic int child(input int n, input logic go_right);
    return 2 * n + 1 + int'(go_right);
  endfunction

  // Nodes on the root-to-leaf path of `way` in a tree of `levels` levels.
  function automatic node_vec_t touch_mask(input logic [2:0] way, input int levels);
    node_vec_t  m;
    int         node;
    logic [2:0] sh;
    m    = '0;
    node = 0;
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        m[node[2:0]] = 1'b1;
        sh           = way >> (levels - 1 - l);
        node         = child(node, sh[0]);
      end
    end
    return m;
  endfunction

  // Value written on that path: each node points away from `way`.
  function automatic node_vec_t touch_val(input logic [2:0] way, input int levels);
    node_vec_t  v;
    int         node;
    logic [2:0] sh;
    v    = '0;
    node = 0;
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        sh           = way >> (levels - 1 - l);
        v[node[2:0]] = ~sh[0];
        node         = child(node, sh[0]);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// Lock-aware tree walk: follows the node bits from the root, but steps into
// the sibling whenever every way under the pointed-to child is locked.
module plru_victim_sel
  import plru_pkg::*;
#(
  parameter int WAY_N = 4
) (
  input  logic [WAY_N-2:0] node_bits,
  input  logic [WAY_N-1:0] lock,
  output logic [WAY_N-1:0] victim
);

  localparam int LEVELS = $clog2(WAY_N);

  node_vec_t              nodes;
  logic [MAX_WAY_N-1:0]   lk;
  logic [MAX_WAY_N-1:0]   avail;
  logic [MAX_WAY_N-1:0]   half_mask;
  int                     node;
  int                     lo;
  int                     span;
  int                     half;
  logic                   go_right;
  logic                   left_free;
  logic                   right_free;

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the loop leaves a value held over and no latch is inferred.
  always_comb begin
    nodes                = '0;
    nodes[WAY_N-2:0]     = node_bits;
    lk                   = '0;
    if (!(&lock)) lk[WAY_N-1:0] = lock;
    avail      = '0;
    half_mask  = '0;
    node       = 0;
    lo         = 0;
    span       = WAY_N;
    half       = 0;
    go_right   = 1'b0;
    left_free  = 1'b0;
    right_free = 1'b0;
    for (int l = 0; l < LEVELS; l++) begin
      half       = span / 2;
      avail      = ~lk >> lo;
      half_mask  = (8'd1 << half) - 8'd1;
      left_free  = |(avail & half_mask);
      right_free = |((avail >> half) & half_mask);
      go_right   = nodes[node[2:0]];
      if (!go_right && !left_free)     go_right = 1'b1;
      else if (go_right && !right_free) go_right = 1'b0;
      if (go_right) lo = lo + half;
      node = child(node, go_right);
      span = half;
    end
    victim = {{(WAY_N-1){1'b0}}, 1'b1} << lo;
  end

endmodule

// File: rtl/plru_set_ctrl.sv
// Per-set tree pseudo-LRU state with touch updates, a registered lock-aware
// victim port and a one-set-per-cycle clear sweep.
module plru_set_ctrl
  import plru_pkg::*;
#(
  parameter int WAY_N    = 4,
  parameter int SET_N    = 256,
  parameter int IDX_BITS = $clog2(SET_N),
  parameter int NODE_N   = WAY_N - 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                acc_valid,
  input  logic [IDX_BITS-1:0] acc_idx,
  input  logic [WAY_N-1:0]    acc_way,
  input  logic                repl_req,
  output logic                repl_ready,
  input  logic [IDX_BITS-1:0] repl_idx,
  input  logic [WAY_N-1:0]    repl_lock,
  output logic                repl_valid,
  output logic [WAY_N-1:0]    repl_way,
  input  logic                clr_req,
  output logic                busy
);

  localparam int LEVELS = $clog2(WAY_N);

  logic [NODE_N-1:0]   tree_q [SET_N];
  sweep_state_e        state_q, state_d;
  logic [IDX_BITS-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                repl_valid_q, repl_valid_d;
  logic [WAY_N-1:0]    repl_way_q, repl_way_d;

  logic [2:0]          acc_way_idx;
  logic                acc_any;
  node_vec_t           t_mask, t_val;
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic [NODE_N-1:0]   wr_row;
  logic [WAY_N-1:0]    victim;
  logic                unused_pad;

  // Scanning downward leaves the lowest set bit as the winner.
  always_comb begin
    acc_way_idx = '0;
    acc_any     = 1'b0;
    for (int w = WAY_N - 1; w >= 0; w--) begin
      if (acc_way[w]) begin
        acc_way_idx = 3'(w);
        acc_any     = 1'b1;
      end
    end
  end

  always_comb begin
    t_mask = touch_mask(acc_way_idx, LEVELS);
    t_val  = touch_val(acc_way_idx, LEVELS);
    wr_en  = 1'b0;
    wr_idx = acc_idx;
    wr_row = (tree_q[acc_idx] & ~t_mask[NODE_N-1:0]) | (t_val[NODE_N-1:0] & t_mask[NODE_N-1:0]);
    if (state_q == CLEAR) begin
      wr_en  = 1'b1;
      wr_idx = cnt_q;
      wr_row = '0;
    end else if (acc_valid && acc_any) begin
      wr_en = 1'b1;
    end
  end

  assign unused_pad = ^{t_mask, t_val};

  // Reads the pre-write row, so a same-cycle touch never affects this result.
  plru_victim_sel #(.WAY_N(WAY_N)) u_victim_sel (
    .node_bits (tree_q[repl_idx]),
    .lock      (repl_lock),
    .victim    (victim)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_BITS'(SET_N - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d == CLEAR);
    repl_valid_d = repl_req && !busy_q;
    repl_way_d   = repl_valid_d ? victim : repl_way_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      repl_valid_q <= 1'b0;
      repl_way_q   <= {{(WAY_N-1){1'b0}}, 1'b1};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      repl_valid_q <= repl_valid_d;
      repl_way_q   <= repl_way_d;
    end
  end

  // NOTE: the replacement array is deliberately reset as flops, since reset
  // must leave every set in its all-zero tree state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int s = 0; s < SET_N; s++) tree_q[s] <= '0;
    end else if (wr_en) begin
      tree_q[wr_idx] <= wr_row;
    end
  end

  assign repl_ready = !busy_q;
  assign repl_valid = repl_valid_q;
  assign repl_way   = repl_way_q;
  assign busy       = busy_q;

endmodule
